// File: rtl/jtag_ahb_pkg.sv
// Shared encodings, widths and types for the JTAG-to-AHB-Lite bridge master.
package jtag_ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO_W  = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/jtag_ahb_timeout.sv
// Consecutive HREADY-low cycle counter; flags expiry on the TIMEOUT_CYCLES-th wait cycle.
module jtag_ahb_timeout
  import jtag_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired_c
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_expired_c = i_count_en && (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/jtag_ahb_master.sv
// JTAG-side request/response to single AHB-Lite word transfers.
// Optional HREADY timeout abort enabled by defining JTAG_AHB_TIMEOUT_EN.
module jtag_ahb_master
  import jtag_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  state_e            r_state;
  req_t              r_req;
  logic              r_ready;
  logic [1:0]        r_htrans;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_expired_c;

`ifdef JTAG_AHB_TIMEOUT_EN
  logic w_in_phase;
  logic w_tmo_clear;
  logic w_tmo_en;

  // Count only while stalled in a bus phase; any HREADY-high cycle restarts the count.
  assign w_in_phase  = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_tmo_clear = !w_in_phase || HREADY;
  assign w_tmo_en    = w_in_phase && !HREADY;

  jtag_ahb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_clear    (w_tmo_clear),
    .i_count_en (w_tmo_en),
    .o_expired_c(w_expired_c)
  );
`else
  // No abort path: TIMEOUT_CYCLES has no effect and the block waits on HREADY forever.
  assign w_expired_c = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_ready     <= 1'b1;
      r_htrans    <= HTRANS_IDLE;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            r_req   <= '{write: REQ_WRITE, addr: REQ_ADDR, wdata: REQ_WDATA};
            r_ready <= 1'b0;
            if (REQ_ADDR[1:0] != 2'b00) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state  <= ST_ADDR;
              r_htrans <= HTRANS_NONSEQ;
            end
          end
        end
        ST_ADDR: begin
          if (w_expired_c) begin
            r_state     <= ST_RESP;
            r_htrans    <= HTRANS_IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else if (HREADY) begin
            r_state  <= ST_DATA;
            r_htrans <= HTRANS_IDLE;
            if (r_req.write) begin
              r_hwdata <= r_req.wdata;
            end
          end
        end
        ST_DATA: begin
          if (w_expired_c) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else if (HREADY) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= HRESP;
            r_rsp_rdata <= (!r_req.write && !HRESP) ? HRDATA : '0;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign REQ_READY = r_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_ERR   = r_rsp_err;
  assign RSP_RDATA = r_rsp_rdata;
  assign HADDR     = r_req.addr;
  assign HWRITE    = r_req.write;
  assign HTRANS    = r_htrans;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = r_hwdata;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Self-checking bench for jtag_ahb_master: directed and randomized transfers against a
// transaction-level latency/result model; honours JTAG_AHB_TIMEOUT_EN.
module tb_jtag_ahb_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  // Model of the values the block should be presenting between transfers.
  logic [31:0] m_rdata;
  logic [31:0] m_hwdata;

  always #5 HCLK = ~HCLK;

  jtag_ahb_master #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'd2);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_rsp_err"}, 32'(RSP_ERR), 32'd0);
    chk({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
  endtask

  // One transfer: aw/dw = HREADY-low cycles in address/data phase; err ends the data
  // phase with a two-cycle HRESP error (needs dw >= 1). Junk requests are held during it.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int aw, input int dw, input logic err, input logic [31:0] rd);
    logic mis;
    logic exp_err;
    int   total;
    int   j;
    logic in_addr, in_data, is_rsp;
    mis     = (addr[1:0] != 2'b00);
    total   = mis ? 1 : aw + dw + 3;
    exp_err = mis || err;
    @(negedge HCLK);
    chk("ready_before_req", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = addr; REQ_WDATA = wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    if (!mis && wr) m_hwdata = wdata;
    m_rdata = (mis || wr || err) ? 32'd0 : rd;
    for (int k = 1; k <= total; k++) begin
      @(negedge HCLK);
      REQ_VALID = 1'b1; REQ_WRITE = 1'($urandom); REQ_ADDR = $urandom; REQ_WDATA = $urandom;
      in_addr = !mis && (k <= aw + 1);
      in_data = !mis && (k > aw + 1) && (k < total);
      is_rsp  = (k == total);
      chk("htrans", 32'(HTRANS), in_addr ? 32'd2 : 32'd0);
      chk("rsp_valid", 32'(RSP_VALID), 32'(is_rsp));
      chk("ready_busy", 32'(REQ_READY), 32'd0);
      HRDATA = $urandom;
      if (in_addr) begin
        chk("haddr", HADDR, addr);
        chk("hwrite", 32'(HWRITE), 32'(wr));
        chk("hsize", 32'(HSIZE), 32'd2);
        HREADY = (k == aw + 1); HRESP = 1'b0;
      end
      if (in_data) begin
        j = k - aw - 1;
        chk("hwdata", HWDATA, m_hwdata);
        HREADY = (j == dw + 1);
        HRESP  = err && (j >= dw);
        if (j == dw + 1) HRDATA = rd;
      end
      if (is_rsp) begin
        chk("rsp_err", 32'(RSP_ERR), 32'(exp_err));
        chk("rsp_rdata", RSP_RDATA, m_rdata);
        chk("hwdata_rsp", HWDATA, m_hwdata);
        HREADY = 1'b1; HRESP = 1'b0;
      end
    end
    @(negedge HCLK);
    REQ_VALID = 1'b0;
    chk("ready_after", 32'(REQ_READY), 32'd1);
    chk("no_extra_rsp", 32'(RSP_VALID), 32'd0);
    chk("htrans_idle_after", 32'(HTRANS), 32'd0);
    chk("rdata_hold", RSP_RDATA, m_rdata);
  endtask

  initial begin
    int rsp_seen;
    logic wr, err, mis;
    int aw, dw;
    logic [31:0] addr;

    HRESETn = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    m_rdata = '0; m_hwdata = '0;
    #1;
    chk_reset_values("por");
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("ready_after_por", 32'(REQ_READY), 32'd1);

    // Zero-wait write, stalled read, error read, misaligned, address-phase waits.
    xfer(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h2000_0010, 32'h0, 0, 3, 1'b0, 32'h1234_5678);
    xfer(1'b0, 32'h2000_0014, 32'h0, 0, 1, 1'b1, 32'hCAFE_F00D);
    xfer(1'b0, 32'h2000_0020, 32'h0, 0, 0, 1'b0, 32'hA5A5_0001);
    xfer(1'b1, 32'h0000_0002, 32'h1111_2222, 0, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h2000_0030, 32'h0, 2, 1, 1'b0, 32'h0BAD_CAFE);
    xfer(1'b1, 32'h2000_0034, 32'h5555_AAAA, 1, 2, 1'b1, 32'h0);

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      mis  = ($urandom_range(0, 7) == 0);
      addr = {$urandom} & 32'hFFFF_FFFC;
      if (mis) addr[1:0] = 2'($urandom_range(1, 3));
      aw   = $urandom_range(0, 3);
      dw   = $urandom_range(0, 3);
      err  = ($urandom_range(0, 3) == 0);
      if (err && dw == 0) dw = 1;
      xfer(wr, addr, $urandom, aw, dw, err, $urandom);
    end

    // Reset during the data phase of a write abandons it silently.
    @(negedge HCLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 32'h3000_0004; REQ_WDATA = 32'h7777_8888;
    HREADY = 1'b1;
    @(negedge HCLK);
    REQ_VALID = 1'b0;
    @(negedge HCLK);
    chk("rst_pre_hwdata", HWDATA, 32'h7777_8888);
    HREADY = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    @(negedge HCLK);
    chk("mid_rst_no_rsp", 32'(RSP_VALID), 32'd0);
    HRESETn = 1'b1; HREADY = 1'b1;
    m_rdata = '0; m_hwdata = '0;
    @(negedge HCLK);
    chk("mid_rst_no_rsp2", 32'(RSP_VALID), 32'd0);
    xfer(1'b0, 32'h3000_0008, 32'h0, 0, 0, 1'b0, 32'h600D_0001);

    // HREADY stuck low in the address phase.
    @(negedge HCLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h4000_0000; HREADY = 1'b0;
`ifdef JTAG_AHB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      @(negedge HCLK);
      REQ_VALID = 1'b0;
      chk("tmo_nonseq", 32'(HTRANS), 32'd2);
      chk("tmo_no_rsp", 32'(RSP_VALID), 32'd0);
    end
    @(negedge HCLK);
    chk("tmo_rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("tmo_rsp_err", 32'(RSP_ERR), 32'd1);
    chk("tmo_rsp_rdata", RSP_RDATA, 32'd0);
    chk("tmo_htrans", 32'(HTRANS), 32'd0);
    m_rdata = '0;
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("tmo_ready", 32'(REQ_READY), 32'd1);
`else
    rsp_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge HCLK);
      REQ_VALID = 1'b0;
      if (RSP_VALID || REQ_READY) rsp_seen++;
    end
    chk("stall_no_rsp", 32'(rsp_seen), 32'd0);
    chk("stall_still_nonseq", 32'(HTRANS), 32'd2);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;
    m_rdata = '0; m_hwdata = '0;
`endif
    xfer(1'b1, 32'h4000_0010, 32'h0123_4567, 0, 1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
